// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the latched
// downstream command.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } arb_cmd_t;

  localparam int         CMD_W    = $bits(arb_cmd_t);
  localparam logic [3:0] BE_ALL   = 4'hF;
  localparam arb_cmd_t   CMD_NONE = '0;

endpackage

// File: rtl/arb_cmd_reg.sv
// Load-enabled command latch. Its contents drive the downstream port directly,
// so an all-zero command means "no strobe".
module arb_cmd_reg
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CMD_W-1:0] cmd_in,
  output logic [CMD_W-1:0] cmd_q
);

  logic [CMD_W-1:0] cmd_d;

  always_comb cmd_d = load ? cmd_in : cmd_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_q <= '0;
    else     cmd_q <= cmd_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single memory port: instruction fetch (read
// only) and data (read/write), with a bounded starvation guard.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_CONSEC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);
  localparam logic       PRI_D = (DATA_PRIORITY != 0);

  arb_state_t       state_q, state_d;
  logic [3:0]       consec_q, consec_d;
  arb_cmd_t         cmd_i, cmd_dside, cmd_next, cmd_q;
  logic [CMD_W-1:0] cmd_raw_q;
  logic             cmd_load;
  logic             i_req, d_req, starve, grant_i, grant_d;

  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    starve  = (consec_q == MAX_C);
    // The non-priority side wins a tie only once the guard has saturated.
    grant_d = d_req && (!i_req || (PRI_D ? !starve : starve));
    grant_i = i_req && !grant_d;
  end

  // A simultaneous d_read/d_write is treated as a write.
  always_comb begin
    cmd_i     = '{rd: 1'b1, wr: 1'b0, be: BE_ALL, addr: i_address, wdata: '0};
    cmd_dside = '{rd: ~d_write, wr: d_write, be: (d_write ? d_byte_enable : BE_ALL),
                  addr: d_address, wdata: d_wdata};
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    cmd_load = 1'b0;
    cmd_next = CMD_NONE;
    unique case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          cmd_load = 1'b1;
          cmd_next = grant_d ? cmd_dside : cmd_i;
          state_d  = grant_d ? SERVE_D : SERVE_I;
          if (grant_d != PRI_D)                     consec_d = '0;
          else if (i_req && d_req && consec_q != MAX_C) consec_d = consec_q + 4'd1;
        end
      end
      SERVE_I, SERVE_D: begin
        // Loading the empty command drops the strobes in the following cycle.
        if (mem_resp) begin
          state_d  = IDLE;
          cmd_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
    end
  end

  arb_cmd_reg u_cmd_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (cmd_load),
    .cmd_in (cmd_next),
    .cmd_q  (cmd_raw_q)
  );

  assign cmd_q           = arb_cmd_t'(cmd_raw_q);
  assign mem_read        = cmd_q.rd;
  assign mem_write       = cmd_q.wr;
  assign mem_byte_enable = cmd_q.be;
  assign mem_address     = cmd_q.addr;
  assign mem_wdata       = cmd_q.wdata;

  assign i_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int DATA_PRIORITY = 1;
  localparam int MAX_CONSEC    = 4;

  logic        clk, rst;
  logic        i_read, i_resp;
  logic [31:0] i_address, i_rdata;
  logic        d_read, d_write, d_resp;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address, d_wdata, d_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  mem_arbiter #(.DATA_PRIORITY(DATA_PRIORITY), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, the side it belongs to,
  // the command the spec says must be presented, and the starvation count.
  bit          m_busy, m_side_d, m_rd, m_wr;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  int          m_consec;

  // Memory responder and observation state.
  bit          mem_active;
  int          mem_wait, mem_lat_fixed, stray_force;
  bit          stray_en, rd_fixed_en;
  logic [31:0] rd_fixed, last_resp_addr, last_i_rdata;
  bit          last_i_resp, last_d_resp;
  int          serve_cycles, resp_total;
  bit          order_q[$];   // 1 = data side completed, 0 = fetch side

  task automatic model_grant();
    bit ireq, dreq, pick_d, pri_d;
    ireq  = i_read;
    dreq  = d_read | d_write;
    pri_d = (DATA_PRIORITY != 0);
    if (!ireq && !dreq) return;
    if (ireq && dreq) begin
      pick_d = (m_consec == MAX_CONSEC) ? !pri_d : pri_d;
      if (pick_d == pri_d) m_consec = (m_consec + 1 > MAX_CONSEC) ? MAX_CONSEC : m_consec + 1;
      else                 m_consec = 0;
    end else begin
      pick_d = dreq;
      if (pick_d != pri_d) m_consec = 0;
    end
    m_busy   = 1'b1;
    m_side_d = pick_d;
    if (pick_d) begin
      m_wr = d_write; m_rd = !d_write;
      m_be = d_write ? d_byte_enable : 4'hF;
      m_addr = d_address; m_wdata = d_wdata;
    end else begin
      m_rd = 1'b1; m_wr = 1'b0; m_be = 4'hF; m_addr = i_address; m_wdata = '0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_consec = 0; mem_active = 0; mem_wait = 0;
    order_q.delete(); serve_cycles = 0;
    last_i_resp = 0; last_d_resp = 0;
  endtask

  // One clock cycle: memory drives at the falling edge, outputs are checked
  // just after it, the model advances, then control returns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    mem_rdata = rd_fixed_en ? rd_fixed : $urandom;
    mem_resp  = 1'b0;
    if (mem_read || mem_write) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_wait   = (mem_lat_fixed > 0) ? mem_lat_fixed - 1 : $urandom_range(0, 3);
      end
      if (mem_wait == 0) begin mem_resp = 1'b1; mem_active = 0; end
      else mem_wait--;
    end else begin
      mem_resp = (stray_force > 0) || (stray_en && $urandom_range(0, 9) == 0);
      if (stray_force > 0) stray_force--;
    end
    #1;
    check("mem_strobes", {mem_read, mem_write}, m_busy ? {m_rd, m_wr} : 2'b00);
    if (m_busy) begin
      check("mem_address", mem_address, m_addr);
      check("mem_byte_enable", mem_byte_enable, m_be);
      if (m_wr) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("resp", {i_resp, d_resp},
          {m_busy && !m_side_d && mem_resp, m_busy && m_side_d && mem_resp});
    check("rdata", {i_rdata, d_rdata}, {mem_rdata, mem_rdata});
    last_i_resp = i_resp;
    last_d_resp = d_resp;
    if (i_resp) begin order_q.push_back(1'b0); last_i_rdata = i_rdata; end
    if (d_resp) order_q.push_back(1'b1);
    if (i_resp || d_resp) begin last_resp_addr = mem_address; resp_total++; end
    if (mem_read || mem_write) serve_cycles++;
    if (m_busy) begin
      if (mem_resp) m_busy = 0;
    end else begin
      model_grant();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    stray_force = 0; stray_en = 0; rd_fixed_en = 0;
    #3;
    check("reset_outputs",
          {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         done;
    logic [9:0] order_v;
    rst = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_byte_enable = 0; d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
    mem_lat_fixed = 0; resp_total = 0; last_resp_addr = 0; last_i_rdata = 0; rd_fixed = 0;

    // Fetch only, memory answers in the third serving cycle.
    reset_dut();
    mem_lat_fixed = 3; rd_fixed_en = 1; rd_fixed = 32'h0000_0013;
    i_read = 1; i_address = 32'h0000_0060;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (last_i_resp) begin i_read = 0; done = 1; end
    end
    check("fetch_done", done, 1'b1);
    repeat (2) cycle();
    check("fetch_serve_cycles", serve_cycles, 3);
    check("fetch_rdata", last_i_rdata, 32'h13);
    check("fetch_resp_count", order_q.size(), 1);
    rd_fixed_en = 0;

    // Simultaneous requests: data write wins, fetch follows.
    reset_dut();
    mem_lat_fixed = 2;
    i_read = 1; i_address = 32'h80;
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
    for (int k = 0; k < 30 && order_q.size() < 2; k++) begin
      cycle();
      if (last_d_resp) d_write = 0;
      if (last_i_resp) i_read = 0;
    end
    check("simul_count", order_q.size(), 2);
    if (order_q.size() == 2) check("simul_order", {order_q[0], order_q[1]}, 2'b10);

    // Starvation guard: data read held, fetch pending.
    reset_dut();
    mem_lat_fixed = 1;
    d_read = 1; d_address = 32'h400;
    i_read = 1; i_address = 32'h500;
    for (int k = 0; k < 80 && order_q.size() < 10; k++) cycle();
    d_read = 0; i_read = 0;
    check("starve_count", order_q.size() >= 10, 1'b1);
    order_v = '0;
    for (int k = 0; k < 10 && k < order_q.size(); k++) order_v[9-k] = order_q[k];
    check("starve_order", order_v, 10'b1111011110);

    // Command latching: address changes while being served.
    reset_dut();
    mem_lat_fixed = 4;
    d_read = 1; d_address = 32'h200;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (mem_read) begin d_address = 32'h300; d_wdata = $urandom; end
      if (last_d_resp) begin d_read = 0; done = 1; end
    end
    check("latch_done", done, 1'b1);
    check("latch_addr", last_resp_addr, 32'h200);

    // Reset two cycles into a fetch: strobe drops at once, no resp, regrant after.
    reset_dut();
    mem_lat_fixed = 10;
    i_read = 1; i_address = 32'h60;
    repeat (3) cycle();
    #2;
    rst = 1;
    #1;
    check("rst_async_read", {mem_read, i_resp}, 2'b00);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    mem_lat_fixed = 2;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (last_i_resp) begin i_read = 0; done = 1; end
    end
    check("rst_regrant_done", done, 1'b1);
    check("rst_regrant_count", order_q.size(), 1);

    // Stray memory response while idle.
    reset_dut();
    stray_force = 1;
    cycle();
    cycle();
    check("stray_idle", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    check("stray_no_resp", order_q.size(), 0);

    // Random traffic.
    reset_dut();
    mem_lat_fixed = 0; stray_en = 1; resp_total = 0;
    for (int k = 0; k < 3000; k++) begin
      if (i_read && last_i_resp) i_read = 0;
      if ((d_read || d_write) && last_d_resp) begin d_read = 0; d_write = 0; end
      if (i_read && m_busy && !m_side_d && $urandom_range(0, 15) == 0) i_read = 0;
      if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1; i_address = $urandom;
      end else if (i_read && $urandom_range(0, 7) == 0) begin
        i_address = $urandom;
      end
      if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin d_read = 1; d_write = 0; end
          2:       begin d_read = 0; d_write = 1; end
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom);
      end else if ((d_read || d_write) && $urandom_range(0, 7) == 0) begin
        d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom);
      end
      cycle();
    end
    check("random_progress", resp_total > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single physical memory port (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata, mem_resp/mem_rdata) between the instruction-fetch requester (read-only) and the data requester (read/write). Sits between the core's fetch/data memory interfaces and the cache or physical memory. Grants one requester at a time and latches the granted command for the whole transaction. A bounded starvation guard stops continuous data traffic from locking out fetches.

Parameters:
DATA_PRIORITY, 1, 1 = data side wins simultaneous requests; 0 = instruction side wins.
MAX_CONSEC, 4, max back-to-back grants to the priority side while the other side waits; range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
i_read  in  1  fetch read request, level, held until i_resp
i_address  in  32  fetch address
i_resp  out  1  one-cycle fetch completion
i_rdata  out  32  fetch read data
d_read  in  1  data read request, level, held until d_resp
d_write  in  1  data write request, level, held until d_resp
d_byte_enable  in  4  data write byte enables
d_address  in  32  data address
d_wdata  in  32  data write data
d_resp  out  1  one-cycle data completion
d_rdata  out  32  data read data
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_byte_enable  out  4  downstream byte enables
mem_address  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_resp  in  1  downstream completion
mem_rdata  in  32  downstream read data

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. State register and command registers reset asynchronously.
- Reset: state=IDLE, consec counter=0. mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp and d_resp are all 0. Asserting rst mid-transaction drops mem_read/mem_write immediately. No resp is issued for the abandoned transaction.
- IDLE: evaluate requests every cycle. A d-side request is d_read|d_write.
  - Only one side requesting: grant that side.
  - Both requesting: grant the priority side, unless consec==MAX_CONSEC, in which case grant the other side.
  - On grant, latch address, wdata, byte_enable and the rd/wr type into command registers. Move to SERVE_x on the next edge.
- SERVE_x: mem_read/mem_write driven from the latched type. mem_address, mem_wdata and mem_byte_enable driven from the latches. The command is stable for the whole transaction even if the requester changes its inputs.
  - For i-side and d-side reads, mem_byte_enable = 4'hF.
  - On mem_resp, the granted side's x_resp=1 in that same cycle (combinational pass-through). The other side's resp stays 0. Next state is IDLE.
  - Strobes deassert in the cycle after mem_resp.
- Latency: request seen at edge N → mem_read/mem_write high from cycle N+1. There is always at least one IDLE cycle between transactions.
- i_rdata = d_rdata = mem_rdata at all times, ungated. Requesters qualify data with their own resp.
- Starvation counter (4-bit):
  - +1 each time the priority side is granted while the other side is requesting, saturating at MAX_CONSEC.
  - Cleared to 0 whenever the non-priority side is granted.
  - Not changed when the priority side is granted alone.
- d_read and d_write both high: illegal, treated as a write.
- A request that drops mid-transaction does not abort it. The transaction completes downstream and the resp is still pulsed.
- mem_resp arriving in IDLE is ignored, and no resp is forwarded.

Decomposition:
- Shared package (rv32i_types): arb_state_t enum {IDLE, SERVE_I, SERVE_D} and an arb_cmd_t struct {rd, wr, be[3:0], addr[31:0], wdata[31:0]}.
- One natural sub-module, arb_cmd_reg: the load-enabled command latch with async reset.
- The FSM, grant logic and starvation counter stay in mem_arbiter.

Test Plan:
- Fetch only: i_read=1, i_address=0x0000_0060, memory resp after 3 cycles with 0x0000_0013 → mem_read high cycles 1-3 with mem_address=0x60, mem_byte_enable=F; i_resp pulses once with i_rdata=0x13; d_resp stays 0.
- Simultaneous request, DATA_PRIORITY=1: i_read plus d_write to 0x100 with wdata=0xDEADBEEF, be=4'b0011 → write completes first (mem_write, be=3); after one IDLE cycle, fetch completes.
- Starvation, MAX_CONSEC=4: d_read held continuously with i_read pending → grant order D,D,D,D,I,D...; counter clears after the I grant.
- Command latching: d_address changes from 0x200 to 0x300 mid-SERVE_D → mem_address holds 0x200 until mem_resp.
- Reset mid-read: rst asserted 2 cycles into SERVE_I → mem_read falls asynchronously; no i_resp; after release, the held i_read is regranted and completes normally.
- Stray mem_resp in IDLE → no i_resp/d_resp pulse and the state stays IDLE.
